// File: rtl/llr_ram_pkg.sv
// Shared types and constants for the LLR BRAM port arbiter and its read-return path.
package llr_ram_pkg;

    localparam int unsigned NREQ  = 3;
    localparam int unsigned IDX_W = 2;

    localparam logic [IDX_W-1:0] REQ_LOAD   = 2'd0;
    localparam logic [IDX_W-1:0] REQ_DEC_RD = 2'd1;
    localparam logic [IDX_W-1:0] REQ_DEC_WR = 2'd2;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } port_tag_t;

    // Modulo-3 increment of a requester index.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == REQ_DEC_WR) ? REQ_LOAD : IDX_W'(i + IDX_W'(1));
    endfunction

endpackage

// File: rtl/llr_ram_rd_return.sv
// Registers the per-port read tags and steers BRAM read data back to the requester.
module llr_ram_rd_return
    import llr_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  port_tag_t                tag_a_d,
    input  port_tag_t                tag_b_d,
    input  logic [DATA_W-1:0]        douta_i,
    input  logic [DATA_W-1:0]        doutb_i,
    output logic [NREQ-1:0]          rvalid_o,
    output logic [NREQ*DATA_W-1:0]   rdata_o
);

    port_tag_t tag_a_q;
    port_tag_t tag_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_a_q <= '0;
            tag_b_q <= '0;
        end else begin
            tag_a_q <= tag_a_d;
            tag_b_q <= tag_b_d;
        end
    end

    // A requester holds at most one port per cycle, so the two returns never collide.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (tag_a_q.valid && tag_a_q.idx == IDX_W'(r)) begin
                rvalid_o[r]                  = 1'b1;
                rdata_o[r*DATA_W +: DATA_W]  = douta_i;
            end
            if (tag_b_q.valid && tag_b_q.idx == IDX_W'(r)) begin
                rvalid_o[r]                  = 1'b1;
                rdata_o[r*DATA_W +: DATA_W]  = doutb_i;
            end
        end
    end

endmodule

// File: rtl/llr_ram_port_arbiter.sv
// Two-port rotating-priority arbiter for the LLR dual-port BRAM with cross-port hazard blocking.
module llr_ram_port_arbiter
    import llr_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          we_i,
    input  logic [NREQ*ADDR_W-1:0]   addr_i,
    input  logic [NREQ*DATA_W-1:0]   wdata_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          rvalid_o,
    output logic [NREQ*DATA_W-1:0]   rdata_o,
    output logic                     ena_o,
    output logic                     wea_o,
    output logic [ADDR_W-1:0]        addra_o,
    output logic [DATA_W-1:0]        dina_o,
    input  logic [DATA_W-1:0]        douta_i,
    output logic                     enb_o,
    output logic                     web_o,
    output logic [ADDR_W-1:0]        addrb_o,
    output logic [DATA_W-1:0]        dinb_o,
    input  logic [DATA_W-1:0]        doutb_i,
    output logic [15:0]              conflict_cnt_o
);

    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  scan [NREQ];
    logic [NREQ-1:0]   act;
    logic [NREQ-1:0]   we_act;
    logic [ADDR_W-1:0] addr_r  [NREQ];
    logic [DATA_W-1:0] wdata_r [NREQ];

    logic              a_found, b_found, a_we, b_we;
    logic [IDX_W-1:0]  a_idx, b_idx;
    logic [ADDR_W-1:0] a_addr;
    port_tag_t         tag_a_d, tag_b_d;

    // Requests are masked while reset is asserted so nothing reaches the BRAM.
    always_comb begin
        act    = req_i & {NREQ{rst_n}};
        we_act = we_i & act;
        for (int r = 0; r < NREQ; r++) begin
            addr_r[r]  = addr_i[r*ADDR_W +: ADDR_W];
            wdata_r[r] = wdata_i[r*DATA_W +: DATA_W];
        end
        scan[0] = ptr;
        scan[1] = next_idx(ptr);
        scan[2] = next_idx(next_idx(ptr));
    end

    // Port A: first active in scan order. Port B: next active that does not hazard against A.
    always_comb begin
        a_found = 1'b0;
        a_idx   = '0;
        a_addr  = '0;
        a_we    = 1'b0;
        b_found = 1'b0;
        b_idx   = '0;
        b_we    = 1'b0;
        for (int p = 0; p < NREQ; p++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!a_found && act[r] && scan[p] == IDX_W'(r)) begin
                    a_found = 1'b1;
                    a_idx   = IDX_W'(r);
                    a_addr  = addr_r[r];
                    a_we    = we_act[r];
                end
            end
        end
        for (int p = 0; p < NREQ; p++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (a_found && !b_found && act[r] && scan[p] == IDX_W'(r) &&
                    a_idx != IDX_W'(r) &&
                    !((addr_r[r] == a_addr) && (we_act[r] || a_we))) begin
                    b_found = 1'b1;
                    b_idx   = IDX_W'(r);
                    b_we    = we_act[r];
                end
            end
        end
    end

    always_comb begin
        gnt_o   = '0;
        ena_o   = 1'b0;
        wea_o   = 1'b0;
        addra_o = '0;
        dina_o  = '0;
        enb_o   = 1'b0;
        web_o   = 1'b0;
        addrb_o = '0;
        dinb_o  = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (a_found && a_idx == IDX_W'(r)) begin
                gnt_o[r] = 1'b1;
                ena_o    = 1'b1;
                wea_o    = we_act[r];
                addra_o  = addr_r[r];
                dina_o   = wdata_r[r];
            end
            if (b_found && b_idx == IDX_W'(r)) begin
                gnt_o[r] = 1'b1;
                enb_o    = 1'b1;
                web_o    = we_act[r];
                addrb_o  = addr_r[r];
                dinb_o   = wdata_r[r];
            end
        end
        tag_a_d.valid = a_found & ~a_we;
        tag_a_d.idx   = a_idx;
        tag_b_d.valid = b_found & ~b_we;
        tag_b_d.idx   = b_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr            <= REQ_LOAD;
            conflict_cnt_o <= '0;
        end else begin
            if (a_found) begin
                ptr <= next_idx(a_idx);
            end
            if (|(req_i & ~gnt_o) && conflict_cnt_o != 16'hFFFF) begin
                conflict_cnt_o <= conflict_cnt_o + 16'd1;
            end
        end
    end

    llr_ram_rd_return #(
        .DATA_W (DATA_W)
    ) u_rd_return (
        .clk      (clk),
        .rst_n    (rst_n),
        .tag_a_d  (tag_a_d),
        .tag_b_d  (tag_b_d),
        .douta_i  (douta_i),
        .doutb_i  (doutb_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o)
    );

endmodule

// File: doc/llr_ram_port_arbiter.md
# llr_ram_port_arbiter

Shares the two ports of the 4-bit LLR dual-port BRAM among three requesters: channel-LLR loader, decoder read, and decoder write-back. Each cycle it grants up to two requests, one per port, with rotating priority. It blocks same-address hazards that the write-first RAM cannot resolve across ports, and routes registered read data back to the correct requester. It sits between the decoder core / input loader and the LLR BRAM instance.

## Interface
- ADDR_W, 7, requester and BRAM address width
- DATA_W, 4, LLR word width
- clk  in  1  shared clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_i  in  3  per-requester request; bit 0 loader, bit 1 decoder read, bit 2 decoder write-back
- we_i  in  3  per-requester write enable, qualified by req_i
- addr_i  in  3*ADDR_W  per-requester address; requester r occupies slice [r*ADDR_W +: ADDR_W]
- wdata_i  in  3*DATA_W  per-requester write data
- gnt_o  out  3  same-cycle grant; the access is issued to the BRAM this cycle
- rvalid_o  out  3  read data valid for requester r, one cycle after a granted read
- rdata_o  out  3*DATA_W  read data; a slice is valid only while its rvalid_o bit is set
- ena_o, wea_o  out  1 each  BRAM port A enable and write enable
- addra_o  out  ADDR_W  BRAM port A address
- dina_o  out  DATA_W  BRAM port A write data
- douta_i  in  DATA_W  BRAM port A read data
- enb_o, web_o, addrb_o, dinb_o, doutb_i  port B equivalents
- conflict_cnt_o  out  16  saturating count of cycles in which at least one active request was denied

## Operation
- Priority pointer ptr ∈ {0,1,2}. The scan order each cycle is ptr, ptr+1, ptr+2, all mod 3.
- The first active requester in scan order is granted port A. The next active requester is granted port B unless it is hazardous.
- Hazard: same address as the port-A grant, with either access being a write. A hazardous requester is skipped, and the scan continues to the remaining requester, which takes port B if it is not itself hazardous.
- At most two grants per cycle. Ungranted requesters must hold req/we/addr/wdata stable until granted.
- gnt_o is combinational from the current inputs and ptr.
- BRAM port signals are combinational copies of the granted requester's fields. An unused port has en=0, we=0, and addr/din driven to 0.
- Read/read to the same address on both ports is permitted and both are granted.
- ptr update: after any cycle with a grant, ptr becomes (port-A requester index + 1) mod 3. With no grant, ptr holds.
- Read return: a registered tag per port stores {valid, requester index} for granted non-write accesses.
  - In the next cycle, rvalid_o[tag] = 1 and that requester's rdata slice = the corresponding douta_i/doutb_i.
  - Writes produce no rvalid.
- conflict_cnt_o increments by 1 on any cycle where req_i & ~gnt_o ≠ 0. It saturates at 0xFFFF.

## Timing
- Grant latency is 0 cycles; read data latency is 1 cycle after the grant (matches the BRAM registered output).
- Back-to-back grants to the same requester are allowed every cycle. The return path is fully pipelined.
- Reset (asynchronous, rst_n=0):
  - ptr=0, port tags invalid, conflict_cnt_o=0.
  - rvalid_o=0 and rdata_o=0. gnt_o and the BRAM enables are forced to 0 while rst_n=0.
- Reset asserted mid-operation: an in-flight read return is dropped, with no rvalid. The requester must reissue after reset.
- Fairness: a continuously requesting requester is granted within 3 cycles if it is hazard-free.

## Structure
- Shared package llr_ram_pkg:
  - NREQ=3.
  - Requester index constants REQ_LOAD=0, REQ_DEC_RD=1, REQ_DEC_WR=2.
  - Port tag typedef {valid, idx[1:0]}.
- One sub-module, llr_ram_rd_return: holds the two registered port tags and performs the rdata/rvalid demux.
- Arbitration and hazard logic stay in the top level.

## Test plan
- Single requester: req_i=3'b010, addr=5, no write → gnt_o=010, ena_o=1, addra_o=5. The next cycle gives rvalid_o=010 with rdata slice 1 = douta_i.
- Three reads, distinct addresses, ptr=0 → grants 011 with loader on A and dec-read on B. The next cycle ptr=1 and write-back is granted. There is no starvation over 6 cycles.
- Hazard: loader writes 0xA to addr 9 while dec-read reads addr 9, ptr=0 → gnt_o=001 and the read is retried. The next cycle the read returns 0xA. conflict_cnt_o increments by 1.
- Same-address read/read on addr 3 from requesters 1 and 2 → both granted on A/B, and both rvalid bits are set next cycle.
- Reset: assert rst_n low the cycle after a granted read → no rvalid. All outputs are 0 and ptr=0 after release.
- Saturation: force 70000 conflict cycles → conflict_cnt_o holds at 0xFFFF.
